// File: rtl/pipelined_control.sv
// pipelined_control: ID-stage decoder with a registered ID/EX boundary.
// Decodes the ID instruction into a fixed-layout control word and destination,
// generates load-use stalls, holds EX for a multi-cycle multiply and handles
// flush / illegal-opcode cases.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   Instruction  ID-stage instruction (held upstream while Stall=1)
//   InstrValid   Instruction is real (0 = bubble)
//   Flush        kill the ID instruction and any in-flight multiply
//   Stall        combinational; ID instruction not consumed this cycle
//   ExCtrl       registered control word {ALUOp[2:0], RegDst, ALUSrc, MemToReg,
//                MemWrite, MemRead, RegWrite}
//   ExDest       registered destination register
//   ExValid      EX holds a real instruction
//   MulBusy      registered; multiply countdown nonzero
//   IllegalOp    registered one-cycle pulse on a consumed illegal instruction
module pipelined_control #(
  parameter int unsigned MUL_LATENCY = 4,
  parameter int unsigned REG_AW      = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       Instruction,
  input  logic              InstrValid,
  input  logic              Flush,
  output logic              Stall,
  output logic [8:0]        ExCtrl,
  output logic [REG_AW-1:0] ExDest,
  output logic              ExValid,
  output logic              MulBusy,
  output logic              IllegalOp
);

  localparam int unsigned CntW = 4;

  localparam logic [5:0] OpRType = 6'b000111;
  localparam logic [5:0] OpLoad  = 6'b001000;
  localparam logic [5:0] OpStore = 6'b001001;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;
  localparam logic [5:0] FnMul = 6'b110010;
  localparam logic [5:0] FnNop = 6'b111111;

  localparam logic [2:0] AluAdd = 3'b000;
  localparam logic [2:0] AluSub = 3'b001;
  localparam logic [2:0] AluAnd = 3'b010;
  localparam logic [2:0] AluOr  = 3'b011;
  localparam logic [2:0] AluMul = 3'b100;
  localparam logic [2:0] AluNop = 3'b111;

  // Instruction fields
  logic [5:0]        op;
  logic [5:0]        funct;
  logic [REG_AW-1:0] rs;
  logic [REG_AW-1:0] rt;
  logic [REG_AW-1:0] rd;
  logic              unused_shamt;

  assign op           = Instruction[31:26];
  assign funct        = Instruction[5:0];
  assign rs           = REG_AW'(Instruction[25:21]);
  assign rt           = REG_AW'(Instruction[20:16]);
  assign rd           = REG_AW'(Instruction[15:11]);
  assign unused_shamt = ^Instruction[10:6];

  // Decode results
  logic              dec_legal;
  logic [8:0]        dec_ctrl;
  logic [REG_AW-1:0] dec_dest;
  logic              dec_reads_rs;
  logic              dec_reads_rt;
  logic              dec_mul;

  always_comb begin
    dec_legal    = 1'b0;
    dec_ctrl     = '0;
    dec_dest     = '0;
    dec_reads_rs = 1'b0;
    dec_reads_rt = 1'b0;
    dec_mul      = 1'b0;
    case (op)
      OpRType: begin
        case (funct)
          FnAdd, FnSub, FnAnd, FnOr, FnMul: begin
            dec_legal    = 1'b1;
            dec_ctrl[0]  = 1'b1;
            dec_ctrl[5]  = 1'b1;
            dec_dest     = rd;
            dec_reads_rs = 1'b1;
            dec_reads_rt = 1'b1;
            case (funct)
              FnSub:   dec_ctrl[8:6] = AluSub;
              FnAnd:   dec_ctrl[8:6] = AluAnd;
              FnOr:    dec_ctrl[8:6] = AluOr;
              FnMul:   dec_ctrl[8:6] = AluMul;
              default: dec_ctrl[8:6] = AluAdd;
            endcase
            dec_mul = (funct == FnMul);
          end
          FnNop: begin
            dec_legal     = 1'b1;
            dec_ctrl[8:6] = AluNop;
          end
          default: ;
        endcase
      end
      OpLoad: begin
        dec_legal     = 1'b1;
        dec_ctrl[0]   = 1'b1;
        dec_ctrl[1]   = 1'b1;
        dec_ctrl[3]   = 1'b1;
        dec_ctrl[4]   = 1'b1;
        dec_ctrl[8:6] = AluAdd;
        dec_dest      = rt;
        dec_reads_rs  = 1'b1;
      end
      OpStore: begin
        dec_legal     = 1'b1;
        dec_ctrl[2]   = 1'b1;
        dec_ctrl[4]   = 1'b1;
        dec_ctrl[8:6] = AluAdd;
        dec_reads_rs  = 1'b1;
        dec_reads_rt  = 1'b1;
      end
      default: ;
    endcase
  end

  // ID/EX state
  logic [8:0]        ex_ctrl_q, ex_ctrl_d;
  logic [REG_AW-1:0] ex_dest_q, ex_dest_d;
  logic              ex_valid_q, ex_valid_d;
  logic              mul_busy_q, mul_busy_d;
  logic              illegal_q, illegal_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic              load_use;

  // A destination of register 0 never creates a dependency.
  always_comb begin
    load_use = ex_valid_q && ex_ctrl_q[1] && (ex_dest_q != '0) && InstrValid &&
               ((dec_reads_rs && (rs == ex_dest_q)) || (dec_reads_rt && (rt == ex_dest_q)));
  end

  assign Stall = mul_busy_q | load_use;

  always_comb begin
    ex_ctrl_d  = ex_ctrl_q;
    ex_dest_d  = ex_dest_q;
    ex_valid_d = ex_valid_q;
    mul_busy_d = mul_busy_q;
    cnt_d      = cnt_q;
    illegal_d  = 1'b0;
    if (Flush) begin
      ex_ctrl_d  = '0;
      ex_dest_d  = '0;
      ex_valid_d = 1'b0;
      mul_busy_d = 1'b0;
      cnt_d      = '0;
    end else if (cnt_q != '0) begin
      // Multiply still occupying EX: hold EX, count down.
      cnt_d      = cnt_q - 1'b1;
      mul_busy_d = (cnt_q != CntW'(1));
    end else if (load_use) begin
      ex_ctrl_d  = '0;
      ex_dest_d  = '0;
      ex_valid_d = 1'b0;
    end else if (InstrValid && dec_legal) begin
      ex_ctrl_d  = dec_ctrl;
      ex_dest_d  = dec_dest;
      ex_valid_d = 1'b1;
      if (dec_mul) begin
        cnt_d      = CntW'(MUL_LATENCY - 1);
        mul_busy_d = (MUL_LATENCY > 1);
      end
    end else begin
      ex_ctrl_d  = '0;
      ex_dest_d  = '0;
      ex_valid_d = 1'b0;
      illegal_d  = InstrValid;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_ctrl_q  <= '0;
      ex_dest_q  <= '0;
      ex_valid_q <= 1'b0;
      mul_busy_q <= 1'b0;
      illegal_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      ex_ctrl_q  <= ex_ctrl_d;
      ex_dest_q  <= ex_dest_d;
      ex_valid_q <= ex_valid_d;
      mul_busy_q <= mul_busy_d;
      illegal_q  <= illegal_d;
      cnt_q      <= cnt_d;
    end
  end

  assign ExCtrl    = ex_ctrl_q;
  assign ExDest    = ex_dest_q;
  assign ExValid   = ex_valid_q;
  assign MulBusy   = mul_busy_q;
  assign IllegalOp = illegal_q;

endmodule

// File: tb/tb_pipelined_control.sv
// tb_pipelined_control: directed self-checking bench for pipelined_control.
// dut uses MUL_LATENCY=4; dut1 uses MUL_LATENCY=1 for the back-to-back case.
module tb_pipelined_control;

  localparam logic [8:0] CAdd   = 9'b000_100_001;
  localparam logic [8:0] CSub   = 9'b001_100_001;
  localparam logic [8:0] CAnd   = 9'b010_100_001;
  localparam logic [8:0] COr    = 9'b011_100_001;
  localparam logic [8:0] CMul   = 9'b100_100_001;
  localparam logic [8:0] CNop   = 9'b111_000_000;
  localparam logic [8:0] CLoad  = 9'b000_011_011;
  localparam logic [8:0] CStore = 9'b000_010_100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0;
  logic        ivalid = 1'b0;
  logic        flush = 1'b0;
  logic        stall;
  logic [8:0]  ex_ctrl;
  logic [4:0]  ex_dest;
  logic        ex_valid, mul_busy, illegal;

  logic [31:0] instr1 = '0;
  logic        ivalid1 = 1'b0;
  logic        flush1 = 1'b0;
  logic        stall1;
  logic [8:0]  ex_ctrl1;
  logic [4:0]  ex_dest1;
  logic        ex_valid1, mul_busy1, illegal1;

  int compared = 0;
  int mismatched = 0;

  always #5 clk = ~clk;

  pipelined_control #(.MUL_LATENCY(4), .REG_AW(5)) dut (
    .clk(clk), .rst(rst), .Instruction(instr), .InstrValid(ivalid), .Flush(flush),
    .Stall(stall), .ExCtrl(ex_ctrl), .ExDest(ex_dest), .ExValid(ex_valid),
    .MulBusy(mul_busy), .IllegalOp(illegal)
  );

  pipelined_control #(.MUL_LATENCY(1), .REG_AW(5)) dut1 (
    .clk(clk), .rst(rst), .Instruction(instr1), .InstrValid(ivalid1), .Flush(flush1),
    .Stall(stall1), .ExCtrl(ex_ctrl1), .ExDest(ex_dest1), .ExValid(ex_valid1),
    .MulBusy(mul_busy1), .IllegalOp(illegal1)
  );

  function automatic logic [31:0] rtype(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd, input logic [5:0] fn);
    return {6'b000111, rs, rt, rd, 5'b00000, fn};
  endfunction

  function automatic logic [31:0] ldst(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt);
    return {op, rs, rt, 16'h0040};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present an instruction and let combinational Stall settle.
  task automatic drive(input logic [31:0] i, input logic v);
    instr  = i;
    ivalid = v;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(rtype(5'd3, 5'd4, 5'd9, 6'b100000), 1'b1);
    tick();
    tick();
    compared++;
    if ({ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall} !== 19'd0) begin
      mismatched++;
      $display("FAIL reset_outputs got %b/%0d/%b/%b/%b/%b want all 0",
               ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall);
    end
    rst = 1'b0;
    drive('0, 1'b0);
    tick();
  endtask

  task automatic test_add();
    int stall_seen = 0;
    drive(rtype(5'd3, 5'd4, 5'd9, 6'b100000), 1'b1);
    tick();
    compared++;
    if (ex_ctrl !== CAdd || ex_dest !== 5'd9 || ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL add_issue got ctrl=%b dest=%0d v=%b want ctrl=%b dest=9 v=1",
               ex_ctrl, ex_dest, ex_valid, CAdd);
    end
    drive('0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (stall !== 1'b0) stall_seen++;
      tick();
    end
    compared++;
    if (stall_seen != 0 || ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || ex_dest !== 5'd0) begin
      mismatched++;
      $display("FAIL add_bubbles got stalls=%0d v=%b ctrl=%b dest=%0d want 0/0/0/0",
               stall_seen, ex_valid, ex_ctrl, ex_dest);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] fns [5];
    logic [8:0] exp [5];
    fns = '{6'b100010, 6'b100100, 6'b100101, 6'b111111, 6'b100000};
    exp = '{CSub, CAnd, COr, CNop, CAdd};
    for (int i = 0; i < 5; i++) begin
      drive(rtype(5'd1, 5'd2, 5'(i + 11), fns[i]), 1'b1);
      tick();
      compared++;
      if (ex_ctrl !== exp[i] || ex_valid !== 1'b1 ||
          ex_dest !== ((i == 3) ? 5'd0 : 5'(i + 11))) begin
        mismatched++;
        $display("FAIL decode_%0d got ctrl=%b dest=%0d v=%b want ctrl=%b", i,
                 ex_ctrl, ex_dest, ex_valid, exp[i]);
      end
    end
    drive('0, 1'b0);
    tick();
  endtask

  task automatic test_load_use();
    int stalls = 0;
    drive(32'h2001_4000, 1'b1);
    tick();
    compared++;
    if (ex_ctrl !== CLoad || ex_dest !== 5'd1 || ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL load_issue got ctrl=%b dest=%0d v=%b want ctrl=%b dest=1 v=1",
               ex_ctrl, ex_dest, ex_valid, CLoad);
    end
    drive(rtype(5'd1, 5'd5, 5'd7, 6'b100000), 1'b1);
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_stall got %b want 1", stall);
    end
    tick();
    compared++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL lu_bubble got v=%b ctrl=%b stall=%b want 0/0/0", ex_valid, ex_ctrl, stall);
    end
    tick();
    compared++;
    if (ex_valid !== 1'b1 || ex_ctrl !== CAdd || ex_dest !== 5'd7) begin
      mismatched++;
      $display("FAIL lu_add got v=%b ctrl=%b dest=%0d want 1/%b/7", ex_valid, ex_ctrl,
               ex_dest, CAdd);
    end
    // Load to r0 creates no hazard.
    drive(ldst(6'b001000, 5'd2, 5'd0), 1'b1);
    tick();
    drive(rtype(5'd0, 5'd0, 5'd7, 6'b100000), 1'b1);
    if (stall !== 1'b0) stalls++;
    tick();
    compared++;
    if (stalls != 0 || ex_ctrl !== CAdd || ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_r0 got stalls=%0d ctrl=%b want 0/%b", stalls, ex_ctrl, CAdd);
    end
    // Store reads rt: hazard through rt.
    drive(ldst(6'b001000, 5'd2, 5'd6), 1'b1);
    tick();
    drive(ldst(6'b001001, 5'd2, 5'd6), 1'b1);
    compared++;
    if (stall !== 1'b1) begin
      mismatched++;
      $display("FAIL lu_rt_stall got %b want 1", stall);
    end
    tick();
    tick();
    // Illegal opcode reads nothing, so no stall even if rs matches.
    drive(ldst(6'b001000, 5'd2, 5'd3), 1'b1);
    tick();
    drive({6'b111000, 5'd3, 5'd3, 16'h0}, 1'b1);
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL lu_illegal_nostall got %b want 0", stall);
    end
    drive('0, 1'b0);
    tick();
    tick();
  endtask

  task automatic test_mul();
    drive(rtype(5'd1, 5'd2, 5'd8, 6'b110010), 1'b1);
    tick();
    compared++;
    if (ex_ctrl !== CMul || ex_dest !== 5'd8 || ex_valid !== 1'b1 || mul_busy !== 1'b1) begin
      mismatched++;
      $display("FAIL mul_issue got ctrl=%b dest=%0d v=%b busy=%b want %b/8/1/1",
               ex_ctrl, ex_dest, ex_valid, mul_busy, CMul);
    end
    drive(rtype(5'd8, 5'd1, 5'd10, 6'b100010), 1'b1);
    for (int i = 0; i < 3; i++) begin
      compared++;
      if (stall !== 1'b1) begin
        mismatched++;
        $display("FAIL mul_stall_%0d got %b want 1", i, stall);
      end
      tick();
      compared++;
      if (ex_ctrl !== CMul || ex_valid !== 1'b1 || mul_busy !== (i < 2)) begin
        mismatched++;
        $display("FAIL mul_hold_%0d got ctrl=%b v=%b busy=%b want %b/1/%b", i, ex_ctrl,
                 ex_valid, mul_busy, CMul, (i < 2));
      end
    end
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL mul_release got stall=%b want 0", stall);
    end
    tick();
    compared++;
    if (ex_ctrl !== CSub || ex_dest !== 5'd10 || ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL mul_next got ctrl=%b dest=%0d want %b/10", ex_ctrl, ex_dest, CSub);
    end
    drive('0, 1'b0);
    tick();
  endtask

  task automatic test_mul_latency1();
    for (int i = 0; i < 3; i++) begin
      instr1  = rtype(5'd1, 5'd2, 5'(i + 20), 6'b110010);
      ivalid1 = 1'b1;
      #1;
      compared++;
      if (stall1 !== 1'b0) begin
        mismatched++;
        $display("FAIL mul1_stall_%0d got %b want 0", i, stall1);
      end
      tick();
      compared++;
      if (ex_ctrl1 !== CMul || ex_dest1 !== 5'(i + 20) || mul_busy1 !== 1'b0) begin
        mismatched++;
        $display("FAIL mul1_issue_%0d got ctrl=%b dest=%0d busy=%b want %b/%0d/0", i,
                 ex_ctrl1, ex_dest1, mul_busy1, CMul, i + 20);
      end
    end
    instr1 = rtype(5'd1, 5'd2, 5'd3, 6'b100010);
    tick();
    compared++;
    if (ex_ctrl1 !== CSub || ex_dest1 !== 5'd3) begin
      mismatched++;
      $display("FAIL mul1_next got ctrl=%b dest=%0d want %b/3", ex_ctrl1, ex_dest1, CSub);
    end
    ivalid1 = 1'b0;
    tick();
  endtask

  task automatic test_illegal();
    drive({6'b111000, 26'h0}, 1'b1);
    compared++;
    if (stall !== 1'b0) begin
      mismatched++;
      $display("FAIL ill_op_stall got %b want 0", stall);
    end
    tick();
    compared++;
    if (ex_valid !== 1'b0 || ex_ctrl !== 9'd0 || illegal !== 1'b1) begin
      mismatched++;
      $display("FAIL ill_op got v=%b ctrl=%b ill=%b want 0/0/1", ex_valid, ex_ctrl, illegal);
    end
    drive(rtype(5'd1, 5'd2, 5'd3, 6'b000001), 1'b1);
    tick();
    compared++;
    if (ex_valid !== 1'b0 || illegal !== 1'b1 || stall !== 1'b0) begin
      mismatched++;
      $display("FAIL ill_funct got v=%b ill=%b stall=%b want 0/1/0", ex_valid, illegal, stall);
    end
    // Illegal encoding on a bubble is not reported.
    drive({6'b111000, 26'h0}, 1'b0);
    tick();
    compared++;
    if (illegal !== 1'b0) begin
      mismatched++;
      $display("FAIL ill_pulse_end got %b want 0", illegal);
    end
  endtask

  task automatic test_flush();
    drive(rtype(5'd1, 5'd2, 5'd8, 6'b110010), 1'b1);
    tick();
    drive(rtype(5'd3, 5'd4, 5'd5, 6'b100000), 1'b1);
    tick();
    flush = 1'b1;
    #1;
    tick();
    flush = 1'b0;
    #1;
    compared++;
    if (ex_valid !== 1'b0 || mul_busy !== 1'b0 || stall !== 1'b0 || ex_ctrl !== 9'd0 ||
        illegal !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_mul got v=%b busy=%b stall=%b ctrl=%b ill=%b want all 0",
               ex_valid, mul_busy, stall, ex_ctrl, illegal);
    end
    // Flushing an illegal instruction raises no IllegalOp.
    drive({6'b111000, 26'h0}, 1'b1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    compared++;
    if (illegal !== 1'b0 || ex_valid !== 1'b0) begin
      mismatched++;
      $display("FAIL flush_illegal got ill=%b v=%b want 0/0", illegal, ex_valid);
    end
    drive('0, 1'b0);
    tick();
  endtask

  task automatic test_reset_mid();
    drive(rtype(5'd1, 5'd2, 5'd8, 6'b110010), 1'b1);
    tick();
    tick();
    rst = 1'b1;
    tick();
    compared++;
    if ({ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall} !== 19'd0) begin
      mismatched++;
      $display("FAIL rst_mul got %b/%0d/%b/%b/%b/%b want all 0",
               ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall);
    end
    rst = 1'b0;
    drive(32'h2001_4000, 1'b1);
    tick();
    drive(rtype(5'd1, 5'd5, 5'd7, 6'b100000), 1'b1);
    rst = 1'b1;
    tick();
    compared++;
    if ({ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall} !== 19'd0) begin
      mismatched++;
      $display("FAIL rst_lu got %b/%0d/%b/%b/%b/%b want all 0",
               ex_ctrl, ex_dest, ex_valid, mul_busy, illegal, stall);
    end
    rst = 1'b0;
    drive(ldst(6'b001001, 5'd10, 5'd10), 1'b1);
    tick();
    compared++;
    if (ex_ctrl !== CStore || ex_dest !== 5'd0 || ex_valid !== 1'b1) begin
      mismatched++;
      $display("FAIL store got ctrl=%b dest=%0d v=%b want %b/0/1", ex_ctrl, ex_dest,
               ex_valid, CStore);
    end
    drive('0, 1'b0);
    tick();
  endtask

  initial begin
    test_reset();
    test_add();
    test_back_to_back();
    test_load_use();
    test_mul();
    test_mul_latency1();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout bench did not finish");
    $fatal(1, "timeout");
  end

endmodule
